cacheline_adaptor: RTL and testbench

//  Sits directly downstream of the I/D-cache arbiter; converts its single-shot 256-bit line

---
 rtl/cacheline_adaptor_pkg.sv | 9 +
 rtl/cacheline_adaptor_if.sv | 25 ++
 rtl/cacheline_adaptor.sv | 54 +++++
 tb/tb_cacheline_adaptor.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/cacheline_adaptor_pkg.sv
// cacheline_adaptor_pkg: shared widths, beat geometry and FSM state type.
package cacheline_adaptor_pkg;
  localparam int LINE_WIDTH = 256;
  localparam int BURST_WIDTH = 64;
  localparam int ADDR_WIDTH = 32;
  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int OFFSET = $clog2(LINE_WIDTH / 8);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
endpackage

// File: rtl/cacheline_adaptor_if.sv
// cacheline_adaptor_if: line-side request/response and burst-side memory signals.
interface cacheline_adaptor_if
  import cacheline_adaptor_pkg::*;
;
  logic [ADDR_WIDTH-1:0] address_i;
  logic read_i;
  logic write_i;
  logic [LINE_WIDTH-1:0] line_i;
  logic [LINE_WIDTH-1:0] line_o;
  logic resp_o;
  logic [ADDR_WIDTH-1:0] address_o;
  logic read_o;
  logic write_o;
  logic [BURST_WIDTH-1:0] burst_o;
  logic [BURST_WIDTH-1:0] burst_i;
  logic resp_i;
  modport slave (
    input address_i, read_i, write_i, line_i, burst_i, resp_i,
    output line_o, resp_o, address_o, read_o, write_o, burst_o
  );
  modport master (
    output address_i, read_i, write_i, line_i, burst_i, resp_i,
    input line_o, resp_o, address_o, read_o, write_o, burst_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns single 256-bit line requests into 4-beat 64-bit memory bursts.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input logic clk,
  input logic rst,
  cacheline_adaptor_if.slave bus
);
  state_e state_q, state_d;
  logic [1:0] beat_q, beat_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic unused_addr;
  assign unused_addr = ^bus.address_i[OFFSET-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q <= '0;
      line_q <= '0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      line_q <= line_d;
      addr_q <= addr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    line_d = line_q;
    addr_d = addr_q;
    case (state_q)
      IDLE: if (bus.read_i || bus.write_i) begin
        addr_d = {bus.address_i[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
        beat_d = '0;
        state_d = bus.read_i ? READ : WRITE;
        if (!bus.read_i) line_d = bus.line_i;
      end
      READ, WRITE: if (bus.resp_i) begin
        if (state_q == READ) line_d[beat_q*BURST_WIDTH +: BURST_WIDTH] = bus.burst_i;
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'(BEATS - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.read_o = state_q == READ;
  assign bus.write_o = state_q == WRITE;
  assign bus.resp_o = state_q == DONE;
  assign bus.address_o = (state_q == READ || state_q == WRITE) ? addr_q : '0;
  assign bus.burst_o = state_q == WRITE ? line_q[beat_q*BURST_WIDTH +: BURST_WIDTH] : '0;
  assign bus.line_o = line_q;
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: vector table of line transactions with queue-based scoreboard.
module tb_cacheline_adaptor;
  logic clk = 0;
  logic rst = 1;
  int n_vec = 0;
  int n_err = 0;
  int resp_cnt = 0;
  int exp_resp = 0;
  logic [255:0] line_sb[$];
  logic [63:0] beat_sb[$];
  typedef struct {
    logic wr;
    logic both;
    logic [31:0] addr;
    logic [255:0] wline;
    logic [3:0][63:0] rd;
    logic [15:0] pat;
  } vec_t;
  vec_t vecs[7];
  cacheline_adaptor_if bus();
  cacheline_adaptor dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.resp_o) resp_cnt++;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic txn(input vec_t v);
    logic wr_eff;
    int beat = 0;
    int cyc = 0;
    wr_eff = v.wr && !v.both;
    bus.read_i = !v.wr || v.both;
    bus.write_i = v.wr || v.both;
    bus.address_i = v.addr;
    bus.line_i = v.wline;
    line_sb.push_back(wr_eff ? v.wline : v.rd);
    if (wr_eff) for (int i = 0; i < 4; i++) beat_sb.push_back(v.wline[i*64 +: 64]);
    exp_resp++;
    tick;
    bus.read_i = 0;
    bus.write_i = 0;
    bus.address_i = $urandom;
    bus.line_i = {8{$urandom}};
    while (beat < 4 && cyc < 64) begin
      bus.resp_i = v.pat[cyc%16];
      bus.burst_i = bus.resp_i ? v.rd[beat] : {$urandom, $urandom};
      @(negedge clk);
      chk("read_o_busy", 256'(bus.read_o), 256'(!wr_eff));
      chk("write_o_busy", 256'(bus.write_o), 256'(wr_eff));
      chk("address_o", 256'(bus.address_o), 256'({v.addr[31:5], 5'b0}));
      chk("resp_o_busy", 256'(bus.resp_o), 256'(0));
      if (wr_eff && bus.resp_i) chk("burst_o", 256'(bus.burst_o), 256'(beat_sb.pop_front()));
      tick;
      if (bus.resp_i) beat++;
      cyc++;
    end
    bus.resp_i = 0;
    if (beat < 4) begin
      n_vec++;
      n_err++;
      $display("FAIL burst_timeout: got %0d beats expected 4", beat);
      line_sb.delete();
      beat_sb.delete();
      exp_resp--;
      return;
    end
    @(negedge clk);
    chk("resp_o_done", 256'(bus.resp_o), 256'(1));
    chk("read_o_done", 256'(bus.read_o), 256'(0));
    chk("write_o_done", 256'(bus.write_o), 256'(0));
    chk("line_o", bus.line_o, line_sb.pop_front());
    tick;
    @(negedge clk);
    chk("resp_o_idle", 256'(bus.resp_o), 256'(0));
    chk("read_o_idle", 256'(bus.read_o), 256'(0));
    chk("write_o_idle", 256'(bus.write_o), 256'(0));
    chk("address_o_idle", 256'(bus.address_o), 256'(0));
  endtask
  initial begin
    vecs[0] = '{0, 0, 32'h0000_1234, '0, {64'hD, 64'hC, 64'hB, 64'hA}, 16'hFFFF};
    vecs[1] = '{1, 0, 32'h0000_0040, {64'h1111, 64'h1112, 64'h1113, 64'h1114}, '0, 16'hFFFF};
    vecs[2] = '{0, 0, 32'hDEAD_BEEF, '0,
                {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h5555_AAAA_5555_AAAA, 64'hCAFE_F00D_0000_0001},
                16'h0059};
    vecs[3] = '{0, 1, 32'h0000_0080, {4{64'hFFFF_0000_FFFF_0000}}, {64'h44, 64'h33, 64'h22, 64'h11}, 16'hFFFF};
    vecs[4] = '{1, 0, 32'hFFFF_FFFF,
                {64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE, 64'h0F0F_0F0F_F0F0_F0F0, 64'h1234_0000_0000_5678},
                '0, 16'hA5A5};
    vecs[5] = '{0, 0, 32'h1000_0020, '0, {64'h4, 64'h3, 64'h2, 64'h1}, 16'hFFFF};
    vecs[6] = '{0, 0, 32'h1000_0040, '0, {64'h8, 64'h7, 64'h6, 64'h5}, 16'hFFFF};
    bus.address_i = '0;
    bus.read_i = 0;
    bus.write_i = 0;
    bus.line_i = '0;
    bus.burst_i = '0;
    bus.resp_i = 0;
    tick;
    tick;
    @(negedge clk);
    chk("rst_read_o", 256'(bus.read_o), 256'(0));
    chk("rst_write_o", 256'(bus.write_o), 256'(0));
    chk("rst_resp_o", 256'(bus.resp_o), 256'(0));
    chk("rst_address_o", 256'(bus.address_o), 256'(0));
    chk("rst_burst_o", 256'(bus.burst_o), 256'(0));
    chk("rst_line_o", bus.line_o, 256'(0));
    rst = 0;
    for (int i = 0; i < 7; i++) txn(vecs[i]);
    bus.read_i = 1;
    bus.address_i = 32'h0000_0300;
    tick;
    bus.read_i = 0;
    for (int i = 0; i < 3; i++) begin
      bus.resp_i = 1;
      bus.burst_i = 64'hBAD0 + 64'(i);
      tick;
    end
    bus.resp_i = 0;
    rst = 1;
    tick;
    @(negedge clk);
    chk("midrst_read_o", 256'(bus.read_o), 256'(0));
    chk("midrst_resp_o", 256'(bus.resp_o), 256'(0));
    chk("midrst_address_o", 256'(bus.address_o), 256'(0));
    chk("midrst_line_o", bus.line_o, 256'(0));
    rst = 0;
    tick;
    @(negedge clk);
    chk("postrst_resp_o", 256'(bus.resp_o), 256'(0));
    chk("postrst_read_o", 256'(bus.read_o), 256'(0));
    txn('{0, 0, 32'h0000_0300, '0, {64'hEE, 64'hDD, 64'hCC, 64'hBB}, 16'hFFFF});
    chk("resp_count", 256'(resp_cnt), 256'(exp_resp));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
